// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
// Bus width, FSM encoding, owner codes and the latched command bundle.
package periph_arb_pkg;

  localparam int BUS_W = 16;

  localparam logic [BUS_W-1:0] ERR_DATA_DEF = 16'hDEAD;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Two-way request picker for the peripheral bus arbiter.
// Round-robin on ties, or M0-first when prio_mode is set.
module rr_arb2
  import periph_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       prio_mode,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = OWN_M0;
    unique case (1'b1)
      (req == 2'b11): begin
        if (prio_mode) begin
          grant_idx = OWN_M0;
        end else begin
          grant_idx = ~last_owner;
        end
      end
      (req == 2'b10): grant_idx = OWN_M1;
      default:        grant_idx = OWN_M0;
    endcase
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter with a wait-state watchdog.
// FSM IDLE -> ACCESS -> RESP; bus and response outputs decode the state.
module periph_bus_arbiter
  import periph_arb_pkg::*;
#(
  parameter int               PRIO_MODE   = 0,
  parameter int               TIMEOUT_CYC = 64,
  parameter logic [BUS_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_m0_req,
  input  logic             i_m0_we,
  input  logic [BUS_W-1:0] i_m0_addr,
  input  logic [BUS_W-1:0] i_m0_wdata,
  input  logic             i_m1_req,
  input  logic             i_m1_we,
  input  logic [BUS_W-1:0] i_m1_addr,
  input  logic [BUS_W-1:0] i_m1_wdata,
  output logic             o_m0_done,
  output logic             o_m1_done,
  output logic [BUS_W-1:0] o_rsp_rdata,
  output logic             o_rsp_err,
  output logic [BUS_W-1:0] o_addr,
  output logic             o_sel,
  output logic             o_we,
  output logic             o_re,
  output logic [BUS_W-1:0] o_wdata,
  input  logic [BUS_W-1:0] i_rdata,
  input  logic             i_rdy,
  output logic             o_busy,
  output logic             o_owner
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [1:0] req_vec;
  logic       gnt_valid;
  logic       gnt_idx;
  cmd_t       m0_cmd;
  cmd_t       m1_cmd;
  logic       in_acc;
  logic       in_resp;

  assign req_vec = {i_m1_req, i_m0_req};

  always_comb begin
    m0_cmd.we    = i_m0_we;
    m0_cmd.addr  = i_m0_addr;
    m0_cmd.wdata = i_m0_wdata;
    m1_cmd.we    = i_m1_we;
    m1_cmd.addr  = i_m1_addr;
    m1_cmd.wdata = i_m1_wdata;
  end

  rr_arb2 u_pick (
    .req         (req_vec),
    .last_owner  (last_q),
    .prio_mode   (PRIO_MODE != 0),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          cmd_d   = gnt_idx ? m1_cmd : m0_cmd;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A late rdy still wins over the watchdog.
        if (i_rdy) begin
          rdata_d = cmd_q.we ? '0 : i_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = cmd_q.we ? '0 : ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_M0;
      last_q  <= OWN_M1;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign o_sel       = in_acc;
  assign o_we        = in_acc & cmd_q.we;
  assign o_re        = in_acc & ~cmd_q.we;
  assign o_addr      = in_acc ? cmd_q.addr : '0;
  assign o_wdata     = in_acc ? cmd_q.wdata : '0;
  assign o_m0_done   = in_resp & (owner_q == OWN_M0);
  assign o_m1_done   = in_resp & (owner_q == OWN_M1);
  assign o_rsp_rdata = in_resp ? rdata_q : '0;
  assign o_rsp_err   = in_resp & err_q;
  assign o_busy      = in_acc | in_resp;
  assign o_owner     = owner_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: two instances (round-robin and fixed
// priority) checked every cycle against a transaction-level model.
module tb_periph_bus_arbiter;

  localparam int          T    = 4;
  localparam logic [15:0] ERRD = 16'hDEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [15:0] addr  [2][2];
  logic [15:0] wdat  [2][2];
  logic        rdy   [2];
  logic [15:0] rdata [2];

  logic        done0 [2];
  logic        done1 [2];
  logic [15:0] rsp   [2];
  logic        err   [2];
  logic [15:0] baddr [2];
  logic        sel   [2];
  logic        bwe   [2];
  logic        bre   [2];
  logic [15:0] bwd   [2];
  logic        busy  [2];
  logic        own   [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    periph_bus_arbiter #(
      .PRIO_MODE   (g),
      .TIMEOUT_CYC (T),
      .ERR_DATA    (ERRD)
    ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_m0_req    (req[g][0]),
      .i_m0_we     (we[g][0]),
      .i_m0_addr   (addr[g][0]),
      .i_m0_wdata  (wdat[g][0]),
      .i_m1_req    (req[g][1]),
      .i_m1_we     (we[g][1]),
      .i_m1_addr   (addr[g][1]),
      .i_m1_wdata  (wdat[g][1]),
      .o_m0_done   (done0[g]),
      .o_m1_done   (done1[g]),
      .o_rsp_rdata (rsp[g]),
      .o_rsp_err   (err[g]),
      .o_addr      (baddr[g]),
      .o_sel       (sel[g]),
      .o_we        (bwe[g]),
      .o_re        (bre[g]),
      .o_wdata     (bwd[g]),
      .i_rdata     (rdata[g]),
      .i_rdy       (rdy[g]),
      .o_busy      (busy[g]),
      .o_owner     (own[g])
    );
  end

  // Model of one arbiter: the transaction in flight (if any), how many
  // wait cycles it has seen, and the completion waiting to be reported.
  typedef struct {
    bit          busy;
    bit          resp;
    bit          own;
    bit          we;
    bit          last;
    bit          err;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          age;
  } mdl_t;

  mdl_t mdl [2];

  function automatic mdl_t mdl_rst();
    mdl_t s;
    s.busy = 0; s.resp = 0; s.own = 0; s.we = 0;
    s.last = 1; s.err = 0; s.age = 0;
    s.addr = 16'h0; s.wd = 16'h0; s.rd = 16'h0;
    return s;
  endfunction

  function automatic mdl_t mdl_next(int d);
    mdl_t s;
    int   w;
    s = mdl[d];
    if (!rst_n) return mdl_rst();
    if (s.resp) begin
      s.resp = 0;
      s.last = s.own;
    end else if (s.busy) begin
      if (rdy[d]) begin
        s.rd = s.we ? 16'h0 : rdata[d];
        s.err = 0; s.busy = 0; s.resp = 1;
      end else if (s.age == T - 1) begin
        s.rd = s.we ? 16'h0 : ERRD;
        s.err = 1; s.busy = 0; s.resp = 1;
      end else begin
        s.age = s.age + 1;
      end
    end else if (req[d] != 2'b00) begin
      if (req[d] == 2'b11) w = (d == 1) ? 0 : (s.last ? 0 : 1);
      else w = req[d][1] ? 1 : 0;
      s.own = (w == 1);
      s.we = we[d][w];
      s.addr = addr[d][w];
      s.wd = wdat[d][w];
      s.age = 0;
      s.busy = 1;
    end
    return s;
  endfunction

  task automatic chk1(string tag, int d, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d obs=%0b exp=%0b", tag, d, obs, exp);
    end
  endtask

  task automatic chk16(string tag, int d, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d obs=%0h exp=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int d, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s dut%0d obs=%0d exp=%0d", tag, d, obs, exp);
    end
  endtask

  task automatic check_outs(int d);
    mdl_t s;
    s = mdl[d];
    chk1("sel", d, sel[d], s.busy);
    chk1("we", d, bwe[d], s.busy & s.we);
    chk1("re", d, bre[d], s.busy & !s.we);
    chk1("done0", d, done0[d], s.resp & !s.own);
    chk1("done1", d, done1[d], s.resp & s.own);
    chk1("busy", d, busy[d], s.busy | s.resp);
    chk1("owner", d, own[d], s.own);
    if (s.busy) begin
      chk16("addr", d, baddr[d], s.addr);
      chk16("wdata", d, bwd[d], s.wd);
    end
    if (s.resp) begin
      chk16("rsp_rdata", d, rsp[d], s.rd);
      chk1("rsp_err", d, err[d], s.err);
      chk16("resp_addr", d, baddr[d], 16'h0);
    end
  endtask

  task automatic chk_zero(int d);
    chk1("rst_sel", d, sel[d], 1'b0);
    chk1("rst_we", d, bwe[d], 1'b0);
    chk1("rst_re", d, bre[d], 1'b0);
    chk1("rst_done0", d, done0[d], 1'b0);
    chk1("rst_done1", d, done1[d], 1'b0);
    chk1("rst_err", d, err[d], 1'b0);
    chk1("rst_busy", d, busy[d], 1'b0);
    chk1("rst_owner", d, own[d], 1'b0);
    chk16("rst_addr", d, baddr[d], 16'h0);
    chk16("rst_wdata", d, bwd[d], 16'h0);
    chk16("rst_rdata", d, rsp[d], 16'h0);
  endtask

  task automatic tick();
    mdl_t n0, n1;
    n0 = mdl_next(0);
    n1 = mdl_next(1);
    @(posedge clk);
    #1;
    mdl[0] = n0;
    mdl[1] = n1;
    check_outs(0);
    check_outs(1);
  endtask

  task automatic start(int d, int m, logic w, logic [15:0] a, logic [15:0] wd);
    req[d][m] = 1'b1;
    we[d][m] = w;
    addr[d][m] = a;
    wdat[d][m] = wd;
  endtask

  // Waits for the master's done pulse; reports ticks taken, sel cycles,
  // and the response seen with the pulse.
  task automatic run_acc(int d, int m, int rdy_from, bit drop,
                         output int n, output int nsel,
                         output logic [15:0] rd, output logic e);
    bit got;
    got = 0; n = 0; nsel = 0; rd = 16'h0; e = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      rdy[d] = (k >= rdy_from);
      tick();
      if (sel[d] === 1'b1) nsel++;
      if (drop && k == 1) req[d][m] = 1'b0;
      if ((m == 0 ? done0[d] : done1[d]) === 1'b1) begin
        got = 1; n = k; rd = rsp[d]; e = err[d];
      end
    end
    chk1("done_seen", d, got, 1'b1);
    req[d][m] = 1'b0;
    rdy[d] = 1'b0;
    tick();
  endtask

  task automatic rand_masters();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        if (req[d][m] && mdl[d].resp && (mdl[d].own == (m == 1))) begin
          if ($urandom_range(3) == 0)
            start(d, m, 1'($urandom), 16'($urandom), 16'($urandom));
          else
            req[d][m] = 1'b0;
        end else if (!req[d][m] && $urandom_range(2) == 0) begin
          start(d, m, 1'($urandom), 16'($urandom), 16'($urandom));
        end
      end
      rdy[d] = ($urandom_range(9) < 5);
      rdata[d] = 16'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nsel;
    logic [15:0] rd;
    logic e;
    int q0 [$];
    int q1 [$];

    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00; we[d] = 2'b00; rdy[d] = 1'b0; rdata[d] = 16'h0;
      for (int m = 0; m < 2; m++) begin
        addr[d][m] = 16'h0; wdat[d][m] = 16'h0;
      end
      mdl[d] = mdl_rst();
    end

    tick();
    tick();
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    tick();

    // Single zero-wait read.
    rdata[0] = 16'h1234;
    start(0, 0, 1'b0, 16'h0204, 16'h0);
    run_acc(0, 0, 1, 0, n, nsel, rd, e);
    chk_int("rd_latency", 0, n, 2);
    chk_int("rd_sel_cycles", 0, nsel, 1);
    chk16("rd_data", 0, rd, 16'h1234);
    chk1("rd_err", 0, e, 1'b0);

    // Write with three wait states.
    rdata[0] = 16'hFFFF;
    start(0, 1, 1'b1, 16'h0300, 16'h00A5);
    run_acc(0, 1, 5, 0, n, nsel, rd, e);
    chk_int("ws_latency", 0, n, 5);
    chk_int("ws_we_cycles", 0, nsel, 4);
    chk1("ws_err", 0, e, 1'b0);

    // Read timeout, then a normal read.
    start(0, 0, 1'b0, 16'h0110, 16'h0);
    run_acc(0, 0, 99, 0, n, nsel, rd, e);
    chk_int("to_latency", 0, n, 5);
    chk_int("to_access_cycles", 0, nsel, 4);
    chk16("to_data", 0, rd, 16'hDEAD);
    chk1("to_err", 0, e, 1'b1);
    rdata[0] = 16'h5A5A;
    start(0, 0, 1'b0, 16'h0112, 16'h0);
    run_acc(0, 0, 1, 0, n, nsel, rd, e);
    chk_int("after_to_latency", 0, n, 2);
    chk16("after_to_data", 0, rd, 16'h5A5A);
    chk1("after_to_err", 0, e, 1'b0);

    // Write timeout returns zero data.
    start(0, 1, 1'b1, 16'h0400, 16'hBEEF);
    run_acc(0, 1, 99, 0, n, nsel, rd, e);
    chk16("wto_data", 0, rd, 16'h0000);
    chk1("wto_err", 0, e, 1'b1);

    // rdy arriving in the final watchdog cycle.
    rdata[0] = 16'h7777;
    start(0, 1, 1'b0, 16'h0500, 16'h0);
    run_acc(0, 1, 5, 0, n, nsel, rd, e);
    chk_int("last_latency", 0, n, 5);
    chk16("last_data", 0, rd, 16'h7777);
    chk1("last_err", 0, e, 1'b0);

    // Dropping req mid-access still completes.
    rdata[0] = 16'h0C0C;
    start(0, 0, 1'b0, 16'h0600, 16'h0);
    run_acc(0, 0, 1, 1, n, nsel, rd, e);
    chk_int("drop_latency", 0, n, 2);
    chk16("drop_data", 0, rd, 16'h0C0C);

    // Reset in the middle of a wait state.
    rdy[0] = 1'b0;
    start(0, 1, 1'b0, 16'h0700, 16'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    mdl[0] = mdl_rst();
    mdl[1] = mdl_rst();
    chk_zero(0);
    chk_zero(1);
    for (int d = 0; d < 2; d++) begin
      start(d, 0, 1'b0, 16'h0800, 16'h0);
      start(d, 1, 1'b1, 16'h0900, 16'h0011);
      rdy[d] = 1'b1;
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Both requests held: arbitration order per instance.
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done0[0] === 1'b1) q0.push_back(0);
      if (done1[0] === 1'b1) q0.push_back(1);
      if (done0[1] === 1'b1) q1.push_back(0);
      if (done1[1] === 1'b1) q1.push_back(1);
    end
    chk_int("rr_count", 0, q0.size(), 4);
    chk_int("prio_count", 1, q1.size(), 4);
    for (int i = 0; i < 4 && i < q0.size(); i++)
      chk_int("rr_order", 0, q0[i], i % 2);
    for (int i = 0; i < 4 && i < q1.size(); i++)
      chk_int("prio_order", 1, q1[i], 0);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) req[d] = 2'b00;
    for (int k = 0; k < 800; k++) begin
      rand_masters();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
